uart_rx_sampler: RTL and testbench

//  UART 8N1 receiver (8O1/8E1-style parity optional) for the board-side serial link.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_rx_sync.sv | 21 ++
 rtl/uart_rx_sampler.sv | 165 ++++++++++++++++
 tb/tb_uart_rx_sampler.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: rate defaults, frame constants, state encodings and ASCII test characters.
package uart_pkg;

  localparam int unsigned CLK_FREQ_DEF  = 10_000_000;
  localparam int unsigned BAUD_RATE_DEF = 115_200;
  localparam int unsigned BIT_COUNT     = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_M     = 8'h4D;
  localparam logic [7:0] ASCII_P     = 8'h50;
  localparam logic [7:0] ASCII_h     = 8'h68;
  localparam logic [7:0] ASCII_i     = 8'h69;
  localparam logic [7:0] ASCII_l     = 8'h6C;
  localparam logic [7:0] ASCII_o     = 8'h6F;
  localparam logic [7:0] ASCII_p     = 8'h70;
  localparam logic [7:0] ASCII_r     = 8'h72;

  // Parity bit that makes data+parity XOR to 0 (even) or 1 (odd).
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receiver sampling mid-bit; valid/ready byte output with framing/overrun flags.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = CLK_FREQ_DEF,
  parameter int unsigned BAUD_RATE    = BAUD_RATE_DEF,
  parameter int unsigned SYMBOL_COUNT = CLK_FREQ / BAUD_RATE,
  parameter int unsigned HALF_COUNT   = SYMBOL_COUNT / 2,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err,
  output logic       busy
);

  localparam logic [15:0] SYM_LAST  = 16'(SYMBOL_COUNT - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_COUNT - 1);
  localparam logic [2:0]  IDX_LAST  = 3'(BIT_COUNT - 1);

  uart_state_t state;
  logic [15:0] clk_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        deliver;
  logic        rx_s;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bad;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
      deliver   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
      par_bad    <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      deliver   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (rx_valid && rx_ready)
        rx_valid <= 1'b0;

      // Delivery is a cycle behind the stop sample; an accept in the same cycle frees the slot.
      if (deliver) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift;
          rx_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
          parity_err <= par_bad;
`endif
        end else begin
          overrun <= 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state   <= ST_START;
            clk_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        ST_START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            if (!rx_s) begin
              state <= ST_DATA;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (clk_cnt == SYM_LAST) begin
            clk_cnt <= '0;
            shift   <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (clk_cnt == SYM_LAST) begin
            clk_cnt <= '0;
            par_bad <= rx_s != parity_bit(shift, PARITY_ODD != 0);
            state   <= ST_STOP;
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
`endif
        ST_STOP: begin
          if (clk_cnt == SYM_LAST) begin
            clk_cnt <= '0;
            if (rx_s) begin
              deliver <= 1'b1;
              state   <= ST_IDLE;
              busy    <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_BREAK;
            end
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        ST_BREAK: begin
          if (rx_s) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Scoreboard bench for uart_rx_sampler: a bit-exact serial driver pushes expected bytes, a monitor pops them on handshake.
`timescale 1ns/1ps
module tb_uart_rx_sampler;
  import uart_pkg::*;

  localparam int unsigned BIT_CLKS = CLK_FREQ_DEF / BAUD_RATE_DEF;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;
  logic       busy;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned n_frame = 0;
  int unsigned n_over = 0;
  int unsigned n_par = 0;
  logic [7:0] exp_q[$];

  logic [7:0] msg [11] = '{ASCII_P, ASCII_h, ASCII_i, ASCII_l, ASCII_i, ASCII_p,
                           ASCII_SPACE, ASCII_M, ASCII_o, ASCII_h, ASCII_r};

  always #5 clk = ~clk;

  uart_rx_sampler #(
    .CLK_FREQ  (CLK_FREQ_DEF),
    .BAUD_RATE (BAUD_RATE_DEF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_b, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^b) ^ bad_par);
`else
    if (bad_par) rx = 1'b1;
`endif
    send_bit(stop_b);
  endtask

  // Monitor samples mid-low-phase, well away from the rising edge.
  always begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) check("unexpected_byte", {24'd0, rx_data}, 32'h100);
        else check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
      end
      if (frame_err) n_frame++;
      if (overrun) n_over++;
      if (parity_err) begin
        n_par++;
        check("par_with_valid", {31'd0, rx_valid}, 32'd1);
        check("par_byte", {24'd0, rx_data}, {24'd0, ASCII_i});
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #2;
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_data", {24'd0, rx_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_flags", {29'd0, frame_err, overrun, parity_err}, 32'd0);

    // 1: single byte
    @(negedge clk);
    exp_q.push_back(ASCII_P);
    send_byte(ASCII_P, 1'b1, 1'b0);
    send_bit(1'b1);
    #2;
    check("t1_busy", {31'd0, busy}, 32'd0);
    check("t1_drain", exp_q.size(), 32'd0);
    check("t1_flags", n_frame + n_over + n_par, 32'd0);

    // 2: short glitch rejected in START
    @(negedge clk);
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (5) @(negedge clk); #2;
    check("t2_busy_start", {31'd0, busy}, 32'd1);
    repeat (60) @(negedge clk); #2;
    check("t2_busy_idle", {31'd0, busy}, 32'd0);
    check("t2_valid", {31'd0, rx_valid}, 32'd0);
    check("t2_flags", n_frame + n_over + n_par, 32'd0);

    // 3: framing error, break, recovery
    @(negedge clk);
    send_byte(8'hA5, 1'b0, 1'b0);
    repeat (2 * BIT_CLKS) @(negedge clk); #2;
    check("t3_frame_err", n_frame, 32'd1);
    check("t3_busy_break", {31'd0, busy}, 32'd1);
    check("t3_valid", {31'd0, rx_valid}, 32'd0);
    @(negedge clk);
    send_bit(1'b1);
    #2;
    check("t3_busy_idle", {31'd0, busy}, 32'd0);
    @(negedge clk);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1, 1'b0);
    send_bit(1'b1);
    #2;
    check("t3_drain", exp_q.size(), 32'd0);

    // 4: overrun while consumer stalls
    @(negedge clk);
    rx_ready = 1'b0;
    exp_q.push_back(ASCII_h);
    send_byte(ASCII_h, 1'b1, 1'b0);
    send_byte(ASCII_i, 1'b1, 1'b0);
    send_bit(1'b1);
    #2;
    check("t4_overrun", n_over, 32'd1);
    check("t4_valid_held", {31'd0, rx_valid}, 32'd1);
    check("t4_data_held", {24'd0, rx_data}, {24'd0, ASCII_h});
    @(negedge clk);
    rx_ready = 1'b1;
    repeat (3) @(negedge clk); #2;
    check("t4_valid_drop", {31'd0, rx_valid}, 32'd0);
    check("t4_drain", exp_q.size(), 32'd0);

    // 5: reset during data bit 4 of 0xFF
    @(negedge clk);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_data", {24'd0, rx_data}, 32'd0);
    check("t5_rst_valid", {31'd0, rx_valid}, 32'd0);
    @(negedge clk);
    repeat (5) send_bit(1'b1);
    exp_q.push_back(ASCII_SPACE);
    send_byte(ASCII_SPACE, 1'b1, 1'b0);
    send_bit(1'b1);
    #2;
    check("t5_drain", exp_q.size(), 32'd0);
    check("t5_flags", n_frame + n_over, 32'd2);

    // 6: back-to-back string, byte index 2 carries a bad parity bit when parity is built in
    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      exp_q.push_back(msg[i]);
      send_byte(msg[i], 1'b1, i == 2);
    end
    send_bit(1'b1);
    #2;
    check("t6_drain", exp_q.size(), 32'd0);
`ifdef UART_RX_PARITY_EN
    check("t6_parity", n_par, 32'd1);
`else
    check("t6_parity", n_par, 32'd0);
`endif
    check("t6_frame", n_frame, 32'd1);
    check("t6_over", n_over, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
